// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Multi-cycle unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH, with
//   borrow = 1 when a < b + bin. DIGIT bits are resolved per RUN cycle,
//   least significant digit first, through a rippled full-subtractor chain.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous reset, active-high
//   start  : request, sampled only while idle
//   a, b   : minuend / subtrahend, captured on the accepted start edge
//   bin    : borrow-in, captured on the accepted start edge
//   busy   : high while an operation is running or completing
//   done   : one-cycle pulse in the cycle diff/borrow have just updated
//   diff   : registered result
//   borrow : registered final borrow-out
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    // One DIGIT-wide slice of the subtract chain; returns {borrow_out, diff_bits}.
    function automatic logic [DIGIT:0] sub_digit(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             br_in
    );
        logic             br;
        logic [DIGIT-1:0] d;
        br = br_in;
        d  = {DIGIT{1'b0}};
        for (int i = 0; i < DIGIT; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [DIGIT:0]   step_s;
    logic [WIDTH-1:0] a_shift_s;
    logic [WIDTH-1:0] b_shift_s;
    logic [WIDTH-1:0] res_shift_s;

    // Current digit computed from the low slice of the operand shifters.
    assign step_s = sub_digit(a_q[DIGIT-1:0], b_q[DIGIT-1:0], br_q);

    // With a single digit there is nothing left to shift; the new digit is the whole result.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign a_shift_s   = {WIDTH{1'b0}};
        assign b_shift_s   = {WIDTH{1'b0}};
        assign res_shift_s = step_s[DIGIT-1:0];
    end else begin : g_multi_digit
        assign a_shift_s   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
        assign b_shift_s   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        // New digits enter at the top so the first digit ends up at bit 0 after N shifts.
        assign res_shift_s = {step_s[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end

    // Next-state and datapath control for IDLE / RUN / DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_shift_s;
                b_d   = b_shift_s;
                res_d = res_shift_s;
                br_d  = step_s[DIGIT];
                if (cnt_q == CW'(N - 1)) begin
                    diff_d   = res_shift_s;
                    borrow_d = step_s[DIGIT];
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            br_q     <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Parametrised multi-cycle unsigned subtractor built from a chain of half/full-subtractor cells. Computes diff = a - b - bin over WIDTH bits, processing DIGIT bits per clock, least significant digit first. Replaces wide combinational subtract chains where area matters more than latency. A start/busy/done handshake lets a controller or sequencer drive it.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 1, bits processed per RUN cycle; must be >= 1 and must divide WIDTH exactly. An elaboration-time error is raised otherwise.
(derived) N = WIDTH/DIGIT, the number of RUN cycles.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-high.
start  input  1  request. Sampled only in IDLE.
a  input  WIDTH  minuend. Captured on the accepted start edge.
b  input  WIDTH  subtrahend. Captured on the accepted start edge.
bin  input  1  borrow-in, used for chaining. Captured on the accepted start edge.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when results update.
diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
borrow  output  1  final borrow-out. Equals 1 iff a < b + bin (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, busy=0, done=0, diff=0, borrow=0.
  - Internal shift registers, digit counter and running borrow are cleared.
  - Overrides every other input, including mid-RUN. A reset mid-RUN abandons the operation: no done pulse, diff/borrow go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0. On an edge with start=1: latch a, b and bin, set the running borrow to bin and the counter to 0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1): on each edge, process the lowest unprocessed DIGIT-bit slice.
  - Per bit, d_i = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br), rippled through the DIGIT bits within one cycle.
  - Diff bits shift into a result register. The running borrow is registered.
  - After the Nth RUN edge: drive diff from the assembled result, drive borrow from the final running borrow, go to DONE.
- DONE: busy=1, done=1 for exactly this one cycle. The next edge goes to IDLE unconditionally.
- Latency:
  - Start accepted at edge E0; done is high in the cycle following edge E_N, i.e. N cycles after acceptance.
  - Back-to-back throughput is one operation per N+2 cycles: a new start is accepted at the earliest on the edge ending DONE... no, on the first IDLE edge after DONE.
- Start is ignored while busy=1: no queuing and no effect on the in-flight operation.
- a, b and bin may change freely after acceptance; only the captured values are used.
- diff and borrow are registered. They change only on the edge that enters DONE (or on reset) and hold their value otherwise, including through subsequent IDLE and the next RUN.
- DIGIT=WIDTH is legal: N=1, and the full subtract happens in one RUN cycle.
- WIDTH=1, DIGIT=1, bin=0 reproduces the half-subtractor truth table in diff/borrow.
- No X propagation: every register has a defined reset value.

Test Plan:
1. WIDTH=8, DIGIT=1, a=0x05, b=0x03, bin=0, start pulsed → busy high; done pulses exactly 8 cycles after the start edge; diff=0x02, borrow=0.
2. WIDTH=8, DIGIT=1, a=0x03, b=0x05, bin=0 → diff=0xFE, borrow=1. Then a=0x00, b=0x00, bin=1 → diff=0xFF, borrow=1. Then a=0xFF, b=0xFF, bin=0 → diff=0x00, borrow=0.
3. WIDTH=8, DIGIT=4, a=0x80, b=0x01 → done 2 cycles after start; diff=0x7F, borrow=0. Repeat with DIGIT=8 → done 1 cycle after start, same result.
4. During RUN of a=0x10, b=0x01, pulse start with a=0xAA, b=0x55 → second request ignored; result diff=0x0F. A new start in the following IDLE cycle is accepted and yields diff=0x55.
5. rst asserted at the 4th RUN cycle of a=0x20, b=0x01 → next cycle: state IDLE, busy=0, diff=0x00, borrow=0, and no done pulse ever appears for that operation.
6. WIDTH=1, DIGIT=1, bin=0, all four (a,b) pairs → (0,0):0/0, (0,1):1/1, (1,0):1/0, (1,1):0/0 for diff/borrow. Plus randomized WIDTH=16, DIGIT=4 checked against the reference model a - b - bin.
